// File: rtl/pll_drp_ctrl.sv
// DRP read-modify-write sequencer for the PLL: holds RST, applies host register entries, waits for LOCKED.
// Optional DRDY/LOCKED wait timeouts are compiled in with `PLL_DRP_TIMEOUT_EN.
module pll_drp_ctrl #(
    parameter int RST_HOLD_CYCLES = 4,
    parameter int DRDY_TIMEOUT    = 64,
    parameter int LOCK_TIMEOUT    = 4096
) (
    input  logic        DCLK,
    input  logic        RST,
    input  logic        START,
    input  logic        CFG_VALID,
    output logic        CFG_READY,
    input  logic [6:0]  CFG_ADDR,
    input  logic [15:0] CFG_MASK,
    input  logic [15:0] CFG_DATA,
    input  logic        CFG_LAST,
    output logic [6:0]  DADDR,
    output logic        DEN,
    output logic        DWE,
    output logic [15:0] DI,
    input  logic [15:0] DO,
    input  logic        DRDY,
    output logic        PLL_RST,
    input  logic        LOCKED,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERROR
);

    localparam int MAX_HD  = (RST_HOLD_CYCLES > DRDY_TIMEOUT) ? RST_HOLD_CYCLES : DRDY_TIMEOUT;
    localparam int MAX_ALL = (MAX_HD > LOCK_TIMEOUT) ? MAX_HD : LOCK_TIMEOUT;
    localparam int CNT_W   = $clog2(MAX_ALL + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD_CYCLES - 1);
`ifdef PLL_DRP_TIMEOUT_EN
    localparam logic [CNT_W-1:0] DRDY_LAST = CNT_W'(DRDY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);
`endif

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_HOLD      = 4'd1,
        S_FETCH     = 4'd2,
        S_RD        = 4'd3,
        S_RD_WAIT   = 4'd4,
        S_WR        = 4'd5,
        S_WR_WAIT   = 4'd6,
        S_RELEASE   = 4'd7,
        S_LOCK_WAIT = 4'd8
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [6:0]        addr_q;
    logic [15:0]       mask_q;
    logic [15:0]       data_q;
    logic              last_q;
    logic              cfg_ready_q;
    logic [6:0]        daddr_q;
    logic              den_q;
    logic              dwe_q;
    logic [15:0]       di_q;
    logic              pll_rst_q;
    logic              busy_q;
    logic              done_q;
    logic [15:0]       di_d;

    // Mask bit 1 keeps the bit read back from the PLL, 0 takes the host bit.
    function automatic logic [15:0] rmw_merge(input logic [15:0] cur,
                                              input logic [15:0] mask,
                                              input logic [15:0] data);
        return (cur & mask) | (data & ~mask);
    endfunction

    assign di_d = rmw_merge(DO, mask_q, data_q);

`ifdef PLL_DRP_TIMEOUT_EN
    logic error_q;
    assign ERROR = error_q;

    // Sticky timeout flag: cleared by RST or an accepted START, set on any wait expiry.
    always_ff @(posedge DCLK) begin
        if (RST) begin
            error_q <= 1'b0;
        end else if (state_q == S_IDLE && START) begin
            error_q <= 1'b0;
        end else if (state_q == S_RD_WAIT && !DRDY && cnt_q == DRDY_LAST) begin
            error_q <= 1'b1;
        end else if (state_q == S_WR_WAIT && !DRDY && cnt_q == DRDY_LAST) begin
            error_q <= 1'b1;
        end else if (state_q == S_LOCK_WAIT && !LOCKED && cnt_q == LOCK_LAST) begin
            error_q <= 1'b1;
        end
    end
`else
    assign ERROR = 1'b0;
`endif

    // Sequencer state, wait counter, latched entry and all registered DRP/status outputs.
    always_ff @(posedge DCLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            addr_q      <= 7'd0;
            mask_q      <= 16'd0;
            data_q      <= 16'd0;
            last_q      <= 1'b0;
            cfg_ready_q <= 1'b0;
            daddr_q     <= 7'd0;
            den_q       <= 1'b0;
            dwe_q       <= 1'b0;
            di_q        <= 16'd0;
            pll_rst_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (START) begin
                        state_q   <= S_HOLD;
                        cnt_q     <= '0;
                        pll_rst_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        state_q     <= S_FETCH;
                        cfg_ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_FETCH: begin
                    if (CFG_VALID && cfg_ready_q) begin
                        addr_q      <= CFG_ADDR;
                        mask_q      <= CFG_MASK;
                        data_q      <= CFG_DATA;
                        last_q      <= CFG_LAST;
                        cfg_ready_q <= 1'b0;
                        daddr_q     <= CFG_ADDR;
                        den_q       <= 1'b1;
                        dwe_q       <= 1'b0;
                        state_q     <= S_RD;
                    end
                end
                S_RD: begin
                    den_q   <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    if (DRDY) begin
                        di_q    <= di_d;
                        daddr_q <= addr_q;
                        den_q   <= 1'b1;
                        dwe_q   <= 1'b1;
                        state_q <= S_WR;
`ifdef PLL_DRP_TIMEOUT_EN
                    end else if (cnt_q == DRDY_LAST) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
`endif
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_WR: begin
                    den_q   <= 1'b0;
                    dwe_q   <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= S_WR_WAIT;
                end
                S_WR_WAIT: begin
                    if (DRDY) begin
                        if (last_q) begin
                            pll_rst_q <= 1'b0;
                            state_q   <= S_RELEASE;
                        end else begin
                            cfg_ready_q <= 1'b1;
                            state_q     <= S_FETCH;
                        end
`ifdef PLL_DRP_TIMEOUT_EN
                    end else if (cnt_q == DRDY_LAST) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
`endif
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_RELEASE: begin
                    cnt_q   <= '0;
                    state_q <= S_LOCK_WAIT;
                end
                S_LOCK_WAIT: begin
                    if (LOCKED) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
`ifdef PLL_DRP_TIMEOUT_EN
                    end else if (cnt_q == LOCK_LAST) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
`endif
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    cfg_ready_q <= 1'b0;
                    den_q       <= 1'b0;
                    dwe_q       <= 1'b0;
                    pll_rst_q   <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign CFG_READY = cfg_ready_q;
    assign DADDR     = daddr_q;
    assign DEN       = den_q;
    assign DWE       = dwe_q;
    assign DI        = di_q;
    assign PLL_RST   = pll_rst_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;

endmodule

// File: tb/tb_pll_drp_ctrl.sv
// Directed self-checking bench for pll_drp_ctrl; the timeout scenario follows `PLL_DRP_TIMEOUT_EN.
module tb_pll_drp_ctrl;

    logic        DCLK = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0;
    logic        CFG_VALID = 1'b0;
    logic        CFG_READY;
    logic [6:0]  CFG_ADDR = 7'd0;
    logic [15:0] CFG_MASK = 16'd0;
    logic [15:0] CFG_DATA = 16'd0;
    logic        CFG_LAST = 1'b0;
    logic [6:0]  DADDR;
    logic        DEN;
    logic        DWE;
    logic [15:0] DI;
    logic [15:0] DO = 16'd0;
    logic        DRDY = 1'b0;
    logic        PLL_RST;
    logic        LOCKED = 1'b0;
    logic        BUSY;
    logic        DONE;
    logic        ERROR;

    int checks = 0;
    int failures = 0;

    pll_drp_ctrl #(
        .RST_HOLD_CYCLES(4),
        .DRDY_TIMEOUT(8),
        .LOCK_TIMEOUT(4096)
    ) dut (
        .DCLK(DCLK), .RST(RST), .START(START),
        .CFG_VALID(CFG_VALID), .CFG_READY(CFG_READY), .CFG_ADDR(CFG_ADDR),
        .CFG_MASK(CFG_MASK), .CFG_DATA(CFG_DATA), .CFG_LAST(CFG_LAST),
        .DADDR(DADDR), .DEN(DEN), .DWE(DWE), .DI(DI), .DO(DO), .DRDY(DRDY),
        .PLL_RST(PLL_RST), .LOCKED(LOCKED), .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR)
    );

    always #5 DCLK = ~DCLK;

    // Hard stop in case the directed sequence ever stalls.
    initial begin
        #2000000;
        $display("FAIL watchdog observed=stall expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge DCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {2'b00, CFG_READY, DADDR, DEN, DWE, DI, PLL_RST, BUSY, DONE, ERROR};
    endfunction

    task automatic start_seq();
        START = 1'b1;
        step();
        START = 1'b0;
        chk("start_pll_rst", 32'(PLL_RST), 32'd1);
        chk("start_busy", 32'(BUSY), 32'd1);
        chk("start_error_clr", 32'(ERROR), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_no_ready", 32'(CFG_READY), 32'd0);
            chk("hold_pll_rst", 32'(PLL_RST), 32'd1);
        end
        step();
        chk("first_ready", 32'(CFG_READY), 32'd1);
    endtask

    // Entered while in FETCH; leaves in FETCH (not last) or RELEASE (last).
    task automatic run_entry(input logic [6:0] a, input logic [15:0] m, input logic [15:0] d,
                             input logic l, input logic [15:0] dov, input int rd_dly,
                             input int wr_dly, input int gap, input logic spur,
                             input logic [15:0] exp_di);
        for (int i = 0; i < gap; i++) begin
            DRDY = spur;
            START = spur;
            step();
            chk("fetch_no_den", 32'(DEN), 32'd0);
            chk("fetch_ready", 32'(CFG_READY), 32'd1);
        end
        DRDY = 1'b0;
        START = 1'b0;
        CFG_VALID = 1'b1;
        CFG_ADDR = a;
        CFG_MASK = m;
        CFG_DATA = d;
        CFG_LAST = l;
        step();
        CFG_VALID = 1'b0;
        chk("rd_den", 32'(DEN), 32'd1);
        chk("rd_dwe", 32'(DWE), 32'd0);
        chk("rd_addr", 32'(DADDR), 32'(a));
        chk("rd_ready_drop", 32'(CFG_READY), 32'd0);
        chk("rd_pll_rst", 32'(PLL_RST), 32'd1);
        step();
        chk("rd_den_pulse", 32'(DEN), 32'd0);
        chk("rd_addr_hold", 32'(DADDR), 32'(a));
        for (int i = 0; i < rd_dly; i++) begin
            step();
            chk("rdwait_no_den", 32'(DEN), 32'd0);
            chk("rdwait_no_dwe", 32'(DWE), 32'd0);
        end
        DRDY = 1'b1;
        DO = dov;
        step();
        DRDY = 1'b0;
        DO = 16'hDEAD;
        chk("wr_den", 32'(DEN), 32'd1);
        chk("wr_dwe", 32'(DWE), 32'd1);
        chk("wr_addr", 32'(DADDR), 32'(a));
        chk("wr_di", 32'(DI), 32'(exp_di));
        chk("wr_pll_rst", 32'(PLL_RST), 32'd1);
        step();
        chk("wr_den_pulse", 32'(DEN), 32'd0);
        chk("wr_di_hold", 32'(DI), 32'(exp_di));
        for (int i = 0; i < wr_dly; i++) begin
            step();
            chk("wrwait_no_den", 32'(DEN), 32'd0);
        end
        DRDY = 1'b1;
        step();
        DRDY = 1'b0;
        chk("after_wr_ready", 32'(CFG_READY), 32'(!l));
        chk("after_wr_pll_rst", 32'(PLL_RST), 32'(!l));
        chk("after_wr_busy", 32'(BUSY), 32'd1);
    endtask

    // Entered in RELEASE; LOCKED raised early to show it is ignored there.
    task automatic finish_lock(input int lock_dly);
        LOCKED = (lock_dly == 0);
        step();
        chk("lockwait_busy", 32'(BUSY), 32'd1);
        chk("lockwait_no_done", 32'(DONE), 32'd0);
        for (int i = 0; i < lock_dly; i++) begin
            START = 1'b1;
            step();
            START = 1'b0;
            chk("lockwait_wait", 32'(DONE), 32'd0);
        end
        LOCKED = 1'b1;
        step();
        LOCKED = 1'b0;
        chk("done_pulse", 32'(DONE), 32'd1);
        chk("done_busy_low", 32'(BUSY), 32'd0);
        chk("done_pll_rst", 32'(PLL_RST), 32'd0);
        step();
        chk("done_single", 32'(DONE), 32'd0);
        chk("idle_busy", 32'(BUSY), 32'd0);
    endtask

    initial begin
        step();
        step();
        chk("reset_outputs", all_outs(), 32'd0);
        RST = 1'b0;
        step();
        chk("idle_outputs", all_outs(), 32'd0);

        // Single entry: 0xF0C3 & 0x1000 | 0x0041 & ~0x1000 = 0x1041
        start_seq();
        run_entry(7'h08, 16'h1000, 16'h0041, 1'b1, 16'hF0C3, 0, 0, 0, 1'b0, 16'h1041);
        finish_lock(0);

        // Three entries with 3-cycle VALID gaps
        start_seq();
        run_entry(7'h11, 16'hFF00, 16'h1234, 1'b0, 16'hABCD, 0, 0, 3, 1'b0, 16'hAB34);
        run_entry(7'h22, 16'h0000, 16'h5A5A, 1'b0, 16'hFFFF, 0, 0, 3, 1'b0, 16'h5A5A);
        run_entry(7'h4E, 16'hFFFF, 16'h0000, 1'b1, 16'h1357, 0, 0, 3, 1'b0, 16'h1357);
        finish_lock(2);

        // Slow DRDY: 10 cycles on read, 1 on write
        start_seq();
        run_entry(7'h7F, 16'h0F0F, 16'hA5A5, 1'b1, 16'h3C3C, 10, 1, 0, 1'b0, 16'hACAC);
        finish_lock(1);

        // Stray START and DRDY while fetching
        start_seq();
        run_entry(7'h05, 16'hF000, 16'h0123, 1'b0, 16'h8FFF, 0, 0, 2, 1'b1, 16'h8123);
        run_entry(7'h06, 16'h00FF, 16'hBEEF, 1'b1, 16'h1200, 2, 0, 2, 1'b1, 16'hBE00);
        finish_lock(3);

        // RST in WR_WAIT aborts everything
        start_seq();
        CFG_VALID = 1'b1;
        CFG_ADDR = 7'h33;
        CFG_MASK = 16'h0000;
        CFG_DATA = 16'h7777;
        CFG_LAST = 1'b1;
        step();
        CFG_VALID = 1'b0;
        step();
        DRDY = 1'b1;
        DO = 16'h0000;
        step();
        DRDY = 1'b0;
        step();
        chk("pre_abort_busy", 32'(BUSY), 32'd1);
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk("abort_outputs", all_outs(), 32'd0);
        step();
        chk("abort_stays_idle", all_outs(), 32'd0);
        start_seq();
        run_entry(7'h33, 16'h0000, 16'h7777, 1'b1, 16'hFFFF, 0, 0, 0, 1'b0, 16'h7777);
        finish_lock(0);

        // Read DRDY never returns
        start_seq();
        CFG_VALID = 1'b1;
        CFG_ADDR = 7'h09;
        CFG_LAST = 1'b1;
        step();
        CFG_VALID = 1'b0;
        step();
        chk("to_rdwait_den", 32'(DEN), 32'd0);
        for (int i = 0; i < 7; i++) begin
            step();
            chk("to_wait_error", 32'(ERROR), 32'd0);
            chk("to_wait_busy", 32'(BUSY), 32'd1);
        end
        step();
`ifdef PLL_DRP_TIMEOUT_EN
        chk("to_error_set", 32'(ERROR), 32'd1);
        chk("to_pll_rst_kept", 32'(PLL_RST), 32'd1);
        chk("to_busy_low", 32'(BUSY), 32'd0);
        chk("to_no_done", 32'(DONE), 32'd0);
        step();
        chk("to_error_sticky", 32'(ERROR), 32'd1);
        chk("to_no_done_late", 32'(DONE), 32'd0);
        start_seq();
        chk("to_error_cleared", 32'(ERROR), 32'd0);
`else
        chk("nto_error_zero", 32'(ERROR), 32'd0);
        chk("nto_still_busy", 32'(BUSY), 32'd1);
        chk("nto_pll_rst", 32'(PLL_RST), 32'd1);
        repeat (20) step();
        chk("nto_still_waiting", 32'(BUSY), 32'd1);
        chk("nto_error_late", 32'(ERROR), 32'd0);
`endif
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk("final_reset", all_outs(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
